if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage that drives the IF/ID pipeline register: owns the PC, requests words from instruction memory, and presents {PC+4, instruction, valid} for IF/ID to latch.
- Handles variable-latency memory, hazard-unit stalls, and branch/jump redirects; wrong-path words are replaced by NOP bubbles.

Parameters:
- n, 32, PC/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP, 32'h0000_0000, instruction word emitted for bubbles

Ports:
- clk  in  1  clock, rising edge
- reset_in  in  1  asynchronous active-low reset
- PC_Write_in  in  1  1 = IF/ID advances this cycle; 0 = stall
- Branch_Taken_in  in  1  taken branch resolved downstream
- Branch_Target_in  in  n  branch target address
- Jump_in  in  1  jump decoded in ID
- Jump_Offset_in  in  26  instr[25:0] of the jump
- Jump_PC_in  in  n  PC+4 of the jump instruction
- Imem_Req_out  out  1  memory request valid
- Imem_Addr_out  out  n  word address (low 2 bits always 0)
- Imem_Data_in  in  32  read data, valid when Imem_Ready_in=1
- Imem_Ready_in  in  1  request completes this cycle
- PC_Counter_output_out  out  n  PC+4 of presented instruction
- Instruction_memory_out  out  32  presented instruction
- IF_Valid_out  out  1  0 = bubble

Behaviour:
- Reset (async, reset_in=0): PC=RESET_PC, state=BOOT, Imem_Req_out=0, Instruction_memory_out=NOP, PC_Counter_output_out=0, IF_Valid_out=0, hold buffer empty.
- States:
  - BOOT: no request; next FETCH. Gives exactly one idle cycle after reset release.
  - FETCH: Imem_Req_out=1, Imem_Addr_out=PC.
  - WAIT: request outstanding.
  - DRAIN: outstanding request belongs to a discarded path.
  - FULL: completed word buffered during a stall.
- Handshake: once Imem_Req_out=1, Imem_Addr_out is stable and the request stays asserted until a cycle with Imem_Ready_in=1. Requests are never withdrawn early. Zero-wait completion (ready in the same cycle as the request) is legal.
- Completion (FETCH/WAIT with ready=1, no redirect):
  - PC <= PC+4, modulo 2^n: 32'hFFFF_FFFC wraps to 0.
  - If PC_Write_in=1: outputs <= {old PC+4, Imem_Data_in, 1}; next state FETCH.
  - If PC_Write_in=0: word and PC+4 go to the hold buffer; outputs unchanged; next state FULL.
- FETCH/WAIT with ready=0: next state WAIT. If PC_Write_in=1, outputs <= {PC_Counter_output_out, NOP, 0}.
- FULL: no request issued. When PC_Write_in=1: outputs <= buffer, valid=1; next state FETCH.
- Redirect target and priority:
  - Branch_Taken_in wins over Jump_in (the branch is the older instruction).
  - Jump target = {Jump_PC_in[31:28], Jump_Offset_in, 2'b00}.
- Redirect effects:
  - PC <= target.
  - Outputs <= {0, NOP, 0}, regardless of PC_Write_in (flush overrides stall).
  - Hold buffer is discarded.
  - Next state: DRAIN if a request is outstanding and not completing this cycle; otherwise FETCH.
- DRAIN: request held at the old address until ready. Returned data is discarded and PC is not incremented. Next state FETCH at the new PC. A second redirect during DRAIN only updates PC.
- Stall with no completion: outputs hold.
- Reset asserted mid-WAIT or DRAIN: everything returns to reset values immediately. Any memory response after reset is ignored because Imem_Req_out=0.

Test Plan:
- Release reset, Imem_Ready_in tied 1, PC_Write_in=1 -> requests at 0,4,8 starting cycle 2. IF/ID sees valid words with PC_Counter_output_out=4,8,12, one per cycle.
- Ready delayed 3 cycles per fetch -> address held stable while pending; IF_Valid_out=0 bubbles while waiting; each word appears once, in order.
- Completion at addr 0x10 while PC_Write_in=0 for 4 cycles -> state FULL, no new request, outputs held. On release: word from 0x10, PC+4=0x14, valid=1; next request at 0x14.
- Branch_Taken_in=1, target 0x200, while request at 0x40 is pending 2 more cycles -> immediate bubble output; request at 0x40 held until ready, data discarded; next request at 0x200.
- Branch_Taken_in=1 (target 0x100) and Jump_in=1 in the same cycle (Jump_PC_in=0x3000_0008, offset 0x0000010) -> next fetch at 0x100, not 0x3000_0040. Jump alone -> 0x3000_0040.
- PC=0xFFFF_FFFC completes -> next fetch address 0. Pulse reset_in low mid-WAIT -> outputs and Imem_Req_out drop immediately; fetch restarts at RESET_PC after one BOOT cycle.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
//   issues word requests to instruction memory, tolerates variable memory
//   latency, buffers a returned word while the pipeline is stalled and
//   replaces wrong-path words with NOP bubbles after a branch/jump redirect.
//
// Ports
//   clk                     rising-edge clock
//   reset_in                asynchronous active-low reset
//   PC_Write_in             1 = IF/ID advances this cycle, 0 = stall
//   Branch_Taken_in         taken branch resolved downstream (highest priority)
//   Branch_Target_in        branch target address
//   Jump_in                 jump decoded in ID
//   Jump_Offset_in          instr[25:0] of the jump
//   Jump_PC_in              PC+4 of the jump instruction
//   Imem_Req_out            memory request valid
//   Imem_Addr_out           word address of the request
//   Imem_Data_in            read data, valid when Imem_Ready_in = 1
//   Imem_Ready_in           request completes this cycle
//   PC_Counter_output_out   PC+4 of the presented instruction
//   Instruction_memory_out  presented instruction
//   IF_Valid_out            0 = bubble
//
// state  | meaning
// -------+-----------------------------------------------------------
// BOOT   | single idle cycle after reset release, no request
// FETCH  | request issued at PC
// WAIT   | request at PC outstanding, waiting for ready
// DRAIN  | outstanding request belongs to a discarded path
// FULL   | completed word parked in the hold buffer during a stall

module if_fetch_stage #(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = '0,
  parameter logic [31:0]  NOP      = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset_in,
  input  logic         PC_Write_in,
  input  logic         Branch_Taken_in,
  input  logic [n-1:0] Branch_Target_in,
  input  logic         Jump_in,
  input  logic [25:0]  Jump_Offset_in,
  input  logic [n-1:0] Jump_PC_in,
  output logic         Imem_Req_out,
  output logic [n-1:0] Imem_Addr_out,
  input  logic [31:0]  Imem_Data_in,
  input  logic         Imem_Ready_in,
  output logic [n-1:0] PC_Counter_output_out,
  output logic [31:0]  Instruction_memory_out,
  output logic         IF_Valid_out
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_FULL  = 3'd4
  } state_t;

  state_t       state, state_d;
  logic [n-1:0] pc, pc_d;
  logic [n-1:0] drain_addr, drain_addr_d;
  logic [n-1:0] buf_pc, buf_pc_d;
  logic [31:0]  buf_instr, buf_instr_d;
  logic [n-1:0] out_pc, out_pc_d;
  logic [31:0]  out_instr, out_instr_d;
  logic         out_valid, out_valid_d;

  logic         redirect;
  logic [n-1:0] target;
  logic [n-1:0] jump_target;
  logic [n-1:0] pc_plus4;

  assign redirect    = Branch_Taken_in | Jump_in;
  assign jump_target = {Jump_PC_in[n-1:28], Jump_Offset_in, 2'b00};
  // The branch is the older instruction, so it wins over a jump in ID.
  assign target      = Branch_Taken_in ? Branch_Target_in : jump_target;
  assign pc_plus4    = pc + n'(4);

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      drain_addr <= '0;
      buf_pc     <= '0;
      buf_instr  <= NOP;
      out_pc     <= '0;
      out_instr  <= NOP;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      drain_addr <= drain_addr_d;
      buf_pc     <= buf_pc_d;
      buf_instr  <= buf_instr_d;
      out_pc     <= out_pc_d;
      out_instr  <= out_instr_d;
      out_valid  <= out_valid_d;
    end
  end

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    drain_addr_d = drain_addr;
    buf_pc_d     = buf_pc;
    buf_instr_d  = buf_instr;
    out_pc_d     = out_pc;
    out_instr_d  = out_instr;
    out_valid_d  = out_valid;

    case (state)
      S_BOOT: begin
        state_d = S_FETCH;
        if (redirect) begin
          pc_d        = target;
          out_pc_d    = '0;
          out_instr_d = NOP;
          out_valid_d = 1'b0;
        end
      end

      S_FETCH, S_WAIT: begin
        if (redirect) begin
          pc_d        = target;
          out_pc_d    = '0;
          out_instr_d = NOP;
          out_valid_d = 1'b0;
          // A request cannot be withdrawn; if it is still pending, keep it
          // alive at the old address and throw its data away later.
          if (Imem_Ready_in) begin
            state_d = S_FETCH;
          end else begin
            state_d      = S_DRAIN;
            drain_addr_d = pc;
          end
        end else if (Imem_Ready_in) begin
          pc_d = pc_plus4;
          if (PC_Write_in) begin
            out_pc_d    = pc_plus4;
            out_instr_d = Imem_Data_in;
            out_valid_d = 1'b1;
            state_d     = S_FETCH;
          end else begin
            buf_pc_d    = pc_plus4;
            buf_instr_d = Imem_Data_in;
            state_d     = S_FULL;
          end
        end else begin
          state_d = S_WAIT;
          // IF/ID consumed what it had; show a bubble until the word arrives.
          if (PC_Write_in) begin
            out_instr_d = NOP;
            out_valid_d = 1'b0;
          end
        end
      end

      S_DRAIN: begin
        if (redirect) pc_d = target;
        if (Imem_Ready_in) state_d = S_FETCH;
      end

      S_FULL: begin
        if (redirect) begin
          pc_d        = target;
          out_pc_d    = '0;
          out_instr_d = NOP;
          out_valid_d = 1'b0;
          state_d     = S_FETCH;
        end else if (PC_Write_in) begin
          out_pc_d    = buf_pc;
          out_instr_d = buf_instr;
          out_valid_d = 1'b1;
          state_d     = S_FETCH;
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  assign Imem_Req_out           = (state == S_FETCH) || (state == S_WAIT) || (state == S_DRAIN);
  assign Imem_Addr_out          = (state == S_DRAIN) ? drain_addr : pc;
  assign PC_Counter_output_out  = out_pc;
  assign Instruction_memory_out = out_instr;
  assign IF_Valid_out           = out_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_in = 1'b0;
  logic        pc_write = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_tgt = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_off = '0;
  logic [31:0] jump_pc = '0;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ready = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address, never equal to NOP.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  assign rdata = memf(addr);

  if_fetch_stage #(.n(32), .RESET_PC(32'h0), .NOP(32'h0)) dut (
    .clk(clk),
    .reset_in(reset_in),
    .PC_Write_in(pc_write),
    .Branch_Taken_in(branch),
    .Branch_Target_in(branch_tgt),
    .Jump_in(jump),
    .Jump_Offset_in(jump_off),
    .Jump_PC_in(jump_pc),
    .Imem_Req_out(req),
    .Imem_Addr_out(addr),
    .Imem_Data_in(rdata),
    .Imem_Ready_in(ready),
    .PC_Counter_output_out(pc_out),
    .Instruction_memory_out(instr_out),
    .IF_Valid_out(valid_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] p, input logic [31:0] i,
                         input logic v);
    chk({tag, "_pc"}, pc_out, p);
    chk({tag, "_instr"}, instr_out, i);
    chk({tag, "_valid"}, {31'b0, valid_out}, {31'b0, v});
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, "_req"}, {31'b0, req}, {31'b0, r});
    if (r) chk({tag, "_addr"}, addr, a);
  endtask

  task automatic do_reset();
    @(negedge clk) reset_in = 1'b0;
    @(negedge clk) reset_in = 1'b1;
    step();
  endtask

  // Reference model state: address of the next instruction IF/ID must accept.
  logic [31:0] exp_pc;
  int consumed;
  logic        p_req, p_ready, p_pcw, p_br, p_jmp, p_valid;
  logic [31:0] p_addr, p_tgt, p_jpc, p_pcout, p_instr;
  logic [25:0] p_off;
  logic [31:0] r;

  initial begin
    // Reset state
    #1;
    chk_req("rst", 1'b0, 32'h0);
    chk_out("rst", 32'h0, 32'h0, 1'b0);
    #11 reset_in = 1'b1;
    chk_req("boot", 1'b0, 32'h0);

    // Zero-wait streaming
    ready = 1'b1; pc_write = 1'b1;
    step();
    chk_req("s0", 1'b1, 32'h0);
    chk_out("s0", 32'h0, 32'h0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_req("stream", 1'b1, 32'(4 * k));
      chk_out("stream", 32'(4 * k), memf(32'(4 * (k - 1))), 1'b1);
    end

    // Three-cycle memory latency for two words at 0xC and 0x10
    for (int w = 0; w < 2; w++) begin
      ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
        step();
        chk_req("lat_hold", 1'b1, 32'hC + 32'(4 * w));
        chk({"lat_bubble", "_valid"}, {31'b0, valid_out}, 32'h0);
      end
      ready = 1'b1;
      step();
      chk_out("lat_word", 32'h10 + 32'(4 * w), memf(32'hC + 32'(4 * w)), 1'b1);
      chk_req("lat_next", 1'b1, 32'h10 + 32'(4 * w));
    end

    // Completion at 0x10 during a 4-cycle stall
    do_reset();
    chk_req("r1", 1'b1, 32'h0);
    for (int k = 0; k < 4; k++) step();
    chk_req("pre_stall", 1'b1, 32'h10);
    pc_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_req("full", 1'b0, 32'h0);
      chk_out("full_hold", 32'h10, memf(32'hC), 1'b1);
    end
    pc_write = 1'b1;
    step();
    chk_out("full_release", 32'h14, memf(32'h10), 1'b1);
    chk_req("full_next", 1'b1, 32'h14);

    // Jump to 0x40, then a branch while the 0x40 request is pending
    jump = 1'b1; jump_pc = 32'h0; jump_off = 26'h10;
    step();
    jump = 1'b0;
    chk_req("jmp40", 1'b1, 32'h40);
    chk_out("jmp40_bubble", 32'h0, 32'h0, 1'b0);
    ready = 1'b0;
    step();
    branch = 1'b1; branch_tgt = 32'h200;
    step();
    branch = 1'b0;
    chk_req("drain0", 1'b1, 32'h40);
    chk_out("drain0_bubble", 32'h0, 32'h0, 1'b0);
    step();
    chk_req("drain1", 1'b1, 32'h40);
    ready = 1'b1;
    step();
    chk_req("after_drain", 1'b1, 32'h200);
    chk_out("drain_discard", 32'h0, 32'h0, 1'b0);
    step();
    chk_out("tgt_word", 32'h204, memf(32'h200), 1'b1);

    // Branch beats jump, then jump alone
    branch = 1'b1; branch_tgt = 32'h100;
    jump = 1'b1; jump_pc = 32'h3000_0008; jump_off = 26'h10;
    step();
    chk_req("prio", 1'b1, 32'h100);
    branch = 1'b0;
    step();
    chk_req("jump_only", 1'b1, 32'h3000_0040);
    jump = 1'b0;

    // PC wrap
    branch = 1'b1; branch_tgt = 32'hFFFF_FFFC;
    step();
    branch = 1'b0;
    chk_req("top", 1'b1, 32'hFFFF_FFFC);
    step();
    chk_req("wrap", 1'b1, 32'h0);
    chk_out("wrap_word", 32'h0, memf(32'hFFFF_FFFC), 1'b1);
    step();
    ready = 1'b0;
    step();
    chk_req("wait4", 1'b1, 32'h4);

    // Asynchronous reset in the middle of WAIT
    #1 reset_in = 1'b0;
    #1;
    chk_req("async_rst", 1'b0, 32'h0);
    chk_out("async_rst", 32'h0, 32'h0, 1'b0);
    ready = 1'b1;
    step();
    chk_req("rst_held", 1'b0, 32'h0);
    #2 reset_in = 1'b1;
    chk_req("boot2", 1'b0, 32'h0);
    step();
    chk_req("restart", 1'b1, 32'h0);

    // Randomized phase against the program-order fetch model
    exp_pc = 32'h0;
    consumed = 0;
    p_req = 1'b0; p_ready = 1'b0; p_pcw = 1'b0; p_br = 1'b0; p_jmp = 1'b0; p_valid = 1'b0;
    p_addr = '0; p_tgt = '0; p_jpc = '0; p_pcout = '0; p_instr = '0; p_off = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) begin
        if (p_br || p_jmp) begin
          exp_pc = p_br ? p_tgt : ((p_jpc & 32'hF000_0000) | (32'(p_off) << 2));
          chk_out("rnd_flush", 32'h0, 32'h0, 1'b0);
        end else if (p_valid && p_pcw) begin
          chk("rnd_order", p_pcout - 32'h4, exp_pc);
          chk("rnd_data", p_instr, memf(p_pcout - 32'h4));
          exp_pc = exp_pc + 32'h4;
          consumed++;
        end else if (p_valid) begin
          chk_out("rnd_hold", p_pcout, p_instr, 1'b1);
        end
        if (p_req && !p_ready) chk_req("rnd_stable", 1'b1, p_addr);
      end
      if (req) chk("rnd_align", {30'b0, addr[1:0]}, 32'h0);

      pc_write = ($urandom_range(0, 99) < 75);
      ready    = ($urandom_range(0, 99) < 50);
      branch   = ($urandom_range(0, 99) < 4);
      jump     = ($urandom_range(0, 99) < 4);
      r = $urandom();
      if ($urandom_range(0, 9) == 0) branch_tgt = 32'hFFFF_FFF0 | (r & 32'hC);
      else branch_tgt = r & 32'hFFFF_FFFC;
      jump_pc  = $urandom();
      r = $urandom();
      jump_off = r[25:0];

      p_req = req; p_addr = addr; p_ready = ready; p_pcw = pc_write;
      p_br = branch; p_jmp = jump; p_tgt = branch_tgt; p_jpc = jump_pc; p_off = jump_off;
      p_valid = valid_out; p_pcout = pc_out; p_instr = instr_out;
      step();
    end
    chk("rnd_progress", {31'b0, consumed > 100}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
